// File: rtl/sum_accumulator.sv
// Block accumulator fed by the n-bit adder: sums BLOCK_LEN two's-complement operands,
// tracks sticky carry/overflow, and hands each block result downstream over valid/ready.
module sum_accumulator #(
  parameter int n         = 4,
  parameter int BLOCK_LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         sat_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] acc_out,
  output logic         carry_sticky,
  output logic         ovf_sticky
);

  localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   count_q, count_d;

  logic [n:0]      sum_raw;
  logic            ovf_now;
  logic            accept;

  assign sum_raw = {1'b0, acc_q} + {1'b0, in_data};
  assign ovf_now = (acc_q[n-1] & in_data[n-1] & ~sum_raw[n-1]) |
                   (~acc_q[n-1] & ~in_data[n-1] & sum_raw[n-1]);
  assign accept  = in_valid & (state_q == ACCUM);

  // Flags always follow the raw sum; sat_en only changes what is loaded into acc.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (sat_en && ovf_now)
              acc_d = acc_q[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
            else
              acc_d = sum_raw[n-1:0];
            carry_d = carry_q | sum_raw[n];
            ovf_d   = ovf_q | ovf_now;
            if (count_q == LAST) begin
              count_d = '0;
              state_d = HOLD;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign acc_out      = acc_q;
  assign carry_sticky = carry_q;
  assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (n=4, BLOCK_LEN=4): directed scenarios plus
// random traffic, all compared against a signed/unsigned arithmetic reference model.
module tb_sum_accumulator;

  localparam int N  = 4;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         sat_en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc_out;
  logic         carry_sticky;
  logic         ovf_sticky;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  logic [N-1:0] mAcc;
  logic         mCarry, mOvf, mHold;
  int           mCount;

  sum_accumulator #(.n(N), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .carry_sticky(carry_sticky), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mAcc = '0; mCarry = 1'b0; mOvf = 1'b0; mHold = 1'b0; mCount = 0;
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".acc"},       acc_out,      mAcc);
    checkOutput({ctx, ".carry"},     carry_sticky, mCarry);
    checkOutput({ctx, ".ovf"},       ovf_sticky,   mOvf);
    checkOutput({ctx, ".in_ready"},  in_ready,     !mHold);
    checkOutput({ctx, ".out_valid"}, out_valid,    mHold);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic sat,
                               input logic ordy, input logic c);
    int sa, sd, ssum, usum;
    in_valid = v; in_data = d; sat_en = sat; out_ready = ordy; clr = c;
    @(posedge clk);
    if (c) begin
      mAcc = '0; mCarry = 1'b0; mOvf = 1'b0; mHold = 1'b0; mCount = 0;
    end else if (!mHold) begin
      if (v) begin
        sa   = $signed(mAcc);
        sd   = $signed(d);
        ssum = sa + sd;
        usum = int'(mAcc) + int'(d);
        if (usum > 15) mCarry = 1'b1;
        if (ssum > 7 || ssum < -8) begin
          mOvf = 1'b1;
          mAcc = sat ? ((ssum > 7) ? 4'h7 : 4'h8) : 4'(usum);
        end else begin
          mAcc = 4'(usum);
        end
        mCount++;
        if (mCount == BL) begin
          mHold  = 1'b1;
          mCount = 0;
        end
      end
    end else if (ordy) begin
      mAcc = '0; mCarry = 1'b0; mOvf = 1'b0; mHold = 1'b0;
    end
    #1;
    checkAll("step");
  endtask

  task automatic feedBlock(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] c, input logic [N-1:0] d, input logic sat);
    applyStimulus(1'b1, a, sat, 1'b0, 1'b0);
    applyStimulus(1'b1, b, sat, 1'b0, 1'b0);
    applyStimulus(1'b1, c, sat, 1'b0, 1'b0);
    applyStimulus(1'b1, d, sat, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; sat_en = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    modelReset();
    #12;
    checkOutput("reset.acc",       acc_out,      4'h0);
    checkOutput("reset.out_valid", out_valid,    1'b0);
    checkOutput("reset.in_ready",  in_ready,     1'b1);
    checkOutput("reset.flags",     {carry_sticky, ovf_sticky}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Positive wrap
    feedBlock(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    checkOutput("wrap.acc",       acc_out,      4'hA);
    checkOutput("wrap.out_valid", out_valid,    1'b1);
    checkOutput("wrap.ovf",       ovf_sticky,   1'b1);
    checkOutput("wrap.carry",     carry_sticky, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("release.in_ready", in_ready, 1'b1);

    // Saturation both signs
    feedBlock(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    checkOutput("satpos.acc", acc_out, 4'h7);
    checkOutput("satpos.ovf", ovf_sticky, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    feedBlock(4'h8, 4'hF, 4'h0, 4'h0, 1'b1);
    checkOutput("satneg.acc",   acc_out,      4'h8);
    checkOutput("satneg.ovf",   ovf_sticky,   1'b1);
    checkOutput("satneg.carry", carry_sticky, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Carry without overflow
    feedBlock(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    checkOutput("carry.acc",   acc_out,      4'hC);
    checkOutput("carry.carry", carry_sticky, 1'b1);
    checkOutput("carry.ovf",   ovf_sticky,   1'b0);

    // Backpressure: result held while in_valid keeps knocking
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      checkOutput("bp.acc", acc_out, 4'hC);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.clearedAcc", acc_out, 4'h0);
    checkOutput("bp.in_ready",   in_ready, 1'b1);

    // clr mid-block
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    checkOutput("clr.acc", acc_out, 4'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
      checkOutput("clr.noValid", out_valid, 1'b0);
    end
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    checkOutput("clr.valid4th", out_valid, 1'b1);
    checkOutput("clr.acc4",     acc_out,   4'h4);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Async reset while holding a result
    feedBlock(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.acc",       acc_out,   4'h0);
    checkOutput("arst.out_valid", out_valid, 1'b0);
    checkOutput("arst.flags",     {carry_sticky, ovf_sticky}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("arst.in_ready", in_ready, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, 4'($urandom), 1'($urandom),
                    ($urandom % 2) == 0, ($urandom % 25) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Sequential stage directly downstream of the team's n-bit combinational adder; consumes its sum, carry and signed-overflow results.
- Accepts a stream of n-bit two's-complement operands over a valid/ready handshake and adds each one into a running accumulator.
- Keeps sticky carry and overflow flags and optionally saturates on signed overflow.
- After BLOCK_LEN accepted operands, presents the block result over an output valid/ready handshake, then clears for the next block.

Parameters:
- n, 4, data width of operands and accumulator (same meaning as the adder's n).
- BLOCK_LEN, 8, operands accumulated per result; legal range 1..2^16.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear; abandons the current block
- sat_en  input  1  1 = saturate on signed overflow, 0 = wrap
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept an operand
- in_data  input  n  two's-complement operand
- out_valid  output  1  block result available
- out_ready  input  1  downstream takes the result
- acc_out  output  n  accumulator value
- carry_sticky  output  1  OR of unsigned carry-outs over the block
- ovf_sticky  output  1  OR of signed overflows over the block

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACCUM; acc_out=0; carry_sticky=0; ovf_sticky=0; out_valid=0; internal count=0.
  - in_ready follows the state, so it reads 1 while in reset.
- States: ACCUM, HOLD.
  - in_ready = (state==ACCUM).
  - out_valid = (state==HOLD).
- Accept: in_valid & in_ready at the rising clock edge. On accept:
  - Raw sum: {c, r} = {0, acc} + {0, in_data}, computed at n+1 bits.
  - Carry: c is bit n of the raw sum.
  - Overflow: v = (acc[n-1] & in_data[n-1] & ~r[n-1]) | (~acc[n-1] & ~in_data[n-1] & r[n-1]).
  - New accumulator: if sat_en & v, load 0111..1 when acc[n-1]=0, or 1000..0 when acc[n-1]=1. Otherwise load r (wrap).
  - Flags: carry_sticky |= c. ovf_sticky |= v. Both use the raw sum, independent of sat_en.
  - Count: count <= count+1.
- Block end: the accept that makes count reach BLOCK_LEN moves the state to HOLD in the same edge, and count resets to 0.
  - out_valid rises 1 cycle after the final accept.
  - acc_out and the flags already hold the final values in that cycle.
- HOLD:
  - acc_out and flags are frozen; in_ready=0, so in_valid is ignored.
  - On out_valid & out_ready: acc=0, flags=0, state=ACCUM.
  - in_ready=1 on the following cycle. This gives one bubble cycle per block; that is required behaviour.
- out_valid, once high, stays high with stable acc_out and flags until out_ready is seen or clr is asserted.
- clr=1 (synchronous) has the highest priority after reset, in any state:
  - acc=0, flags=0, count=0, state=ACCUM.
  - Any simultaneous accept is discarded.
  - A pending HOLD result is dropped: out_valid falls without a handshake.
- BLOCK_LEN=1: every accept goes straight to HOLD.
- sat_en is sampled per accept and may change mid-block.
- Asynchronous reset mid-block or mid-HOLD returns all outputs to their reset values immediately, with no clock edge required.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

Test Plan (n=4, BLOCK_LEN=4):
- Positive wrap: sat_en=0; accept 1,2,3,4 back-to-back → acc sequence 1,3,6,A; out_valid=1 the cycle after the 4th accept; acc_out=4'hA; ovf_sticky=1; carry_sticky=0.
- Saturation, both signs:
  - sat_en=1; accept 1,2,3,4 → acc_out=4'h7, ovf_sticky=1.
  - Next block: accept 8,F,0,0 → acc_out=4'h8, ovf_sticky=1, carry_sticky=1.
- Carry without overflow: sat_en=0; accept F,F,F,F → acc sequence F,E,D,C; acc_out=4'hC; carry_sticky=1; ovf_sticky=0.
- Backpressure:
  - Complete a block, hold out_ready=0 for 5 cycles while in_valid=1 → out_valid stays 1, acc_out is stable, in_ready=0, no accepts occur.
  - Then assert out_ready for 1 cycle → next cycle acc_out=0, flags=0, in_ready=1.
- clr mid-block: accept 5,5, then assert clr together with in_valid (data 3) → acc_out=0, count restarts, and 4 further accepts are needed before out_valid.
- Async reset:
  - In HOLD with acc_out=4'hA, drop rst_n between clock edges → acc_out=0, out_valid=0, flags=0 immediately.
  - After release, in_ready=1.
